bnn_sample_sequencer: RTL and testbench

BNN_SAMPLE_SEQUENCER -- requirements
Module: bnn_sample_sequencer

---
 rtl/bnn_seq_pkg.sv | 17 +
 rtl/bnn_feat_packer.sv | 43 ++++
 rtl/bnn_sample_sequencer.sv | 97 +++++++++
 tb/tb_bnn_sample_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_seq_pkg.sv
// Shared types for the BNN sample sequencer: FSM state encoding and run-length helper.
// No logic of its own; no latency, no backpressure.
package bnn_seq_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  // One cycle per hidden neuron, one per class, plus the final argmax settle.
  function automatic int calc_run_cycles(input int hidden_cnt, input int class_cnt);
    return hidden_cnt + class_cnt + 1;
  endfunction

endpackage

// File: rtl/bnn_feat_packer.sv
// Feature shift register: each accepted word enters at the LSB, so the first feature ends at the MSB.
// Zero latency: last is combinational on the handshake of the final feature; no backpressure of its own.
module bnn_feat_packer #(
  parameter int FEAT_CNT  = 11,
  parameter int FEAT_BITS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          shift_en,
  input  logic [FEAT_BITS-1:0]          din,
  output logic [FEAT_BITS*FEAT_CNT-1:0] feat_packed,
  output logic                          last
);

  localparam int PW = FEAT_BITS * FEAT_CNT;
  localparam int CW = (FEAT_CNT > 1) ? $clog2(FEAT_CNT) : 1;

  logic [PW-1:0] packed_q, packed_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    packed_d = packed_q;
    cnt_d    = cnt_q;
    last     = shift_en && (cnt_q == CW'(FEAT_CNT - 1));
    if (shift_en) begin
      packed_d = (packed_q << FEAT_BITS) | PW'(din);
      cnt_d    = last ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      packed_q <= '0;
      cnt_q    <= '0;
    end else begin
      packed_q <= packed_d;
      cnt_q    <= cnt_d;
    end
  end

  assign feat_packed = packed_q;

endmodule

// File: rtl/bnn_sample_sequencer.sv
// Loads FEAT_CNT feature words, strobes the classifier, waits RUN_CYCLES and presents its prediction.
// Result appears 1+RUN_CYCLES cycles after the last feature; input stalls until the result is taken.
module bnn_sample_sequencer
  import bnn_seq_pkg::*;
#(
  parameter int FEAT_CNT   = 11,
  parameter int FEAT_BITS  = 4,
  parameter int HIDDEN_CNT = 40,
  parameter int CLASS_CNT  = 7,
  parameter int RUN_CYCLES = calc_run_cycles(HIDDEN_CNT, CLASS_CNT)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [FEAT_BITS-1:0]          in_data,
  output logic [FEAT_BITS*FEAT_CNT-1:0] features,
  output logic                          clf_rst,
  input  logic [$clog2(CLASS_CNT)-1:0]  clf_prediction,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(CLASS_CNT)-1:0]  out_class
);

  localparam int CYC_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
  localparam int CLS_W = $clog2(CLASS_CNT);

  seq_state_e       state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [CLS_W-1:0] out_class_q, out_class_d;
  logic             shift_en;
  logic             feat_last;

  bnn_feat_packer #(
    .FEAT_CNT  (FEAT_CNT),
    .FEAT_BITS (FEAT_BITS)
  ) u_packer (
    .clk         (clk),
    .rst         (rst),
    .shift_en    (shift_en),
    .din         (in_data),
    .feat_packed (features),
    .last        (feat_last)
  );

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    out_class_d = out_class_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    clf_rst     = 1'b1;
    case (state_q)
      ST_LOAD: begin
        // Gate with rst so nothing is offered while the block is held in reset.
        in_ready = !rst;
        if (feat_last) state_d = ST_START;
      end
      ST_START: begin
        cyc_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        clf_rst = 1'b0;
        if (cyc_q == CYC_W'(RUN_CYCLES - 1)) begin
          out_class_d = clf_prediction;
          cyc_d       = '0;
          state_d     = ST_DONE;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_LOAD;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  assign shift_en = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      cyc_q       <= '0;
      out_class_q <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      out_class_q <= out_class_d;
    end
  end

  assign out_class = out_class_q;

endmodule

// File: tb/tb_bnn_sample_sequencer.sv
// Randomized bench for bnn_sample_sequencer with a behavioural classifier and expected-result model.
module tb_bnn_sample_sequencer;

  localparam int FC  = 11;
  localparam int FB  = 4;
  localparam int NC  = 7;
  localparam int RUN = 40 + 7 + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [FB-1:0] in_data = '0;
  logic [FB*FC-1:0] features;
  logic          clf_rst;
  logic [2:0]    clf_prediction;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [2:0]    out_class;

  int n_checks = 0;
  int n_fail   = 0;
  int lowcnt   = 0;
  logic [FB-1:0] cur [FC];

  bnn_sample_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .features       (features),
    .clf_rst        (clf_rst),
    .clf_prediction (clf_prediction),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_class      (out_class)
  );

  always #5 clk = ~clk;

  function automatic int nib_sum(input logic [FB*FC-1:0] p);
    int s = 0;
    for (int i = 0; i < FC; i++) s += int'(p[i*FB +: FB]);
    return s;
  endfunction

  function automatic logic [FB*FC-1:0] exp_packed();
    logic [FB*FC-1:0] p = '0;
    for (int i = 0; i < FC; i++) p = (p << FB) | (FB*FC)'(cur[i]);
    return p;
  endfunction

  // Classifier stand-in: answer = nibble sum mod 7, valid only once RUN-1 cycles have elapsed since release.
  always @(posedge clk) lowcnt <= clf_rst ? 0 : lowcnt + 1;

  always_comb begin
    int mc;
    mc = nib_sum(features) % NC;
    clf_prediction = (lowcnt >= RUN - 1) ? 3'(mc) : 3'((mc + 1) % NC);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [FB-1:0] w);
    int t = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && t < 100) begin
      step();
      t++;
    end
    chk("in_rdy_wait", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic load_sample(input int gap_lo, input int gap_hi);
    for (int i = 0; i < FC; i++) begin
      int gap = $urandom_range(gap_hi, gap_lo);
      in_valid = 1'b0;
      repeat (gap) step();
      send_word(cur[i]);
    end
  endtask

  task automatic rand_cur();
    for (int i = 0; i < FC; i++) cur[i] = FB'($urandom);
  endtask

  // Entered in the cycle right after the last feature handshake.
  task automatic finish_sample(input bit hold_vld, input int hold, input bit rdy_hi);
    logic [FB*FC-1:0] ep;
    int ecls, lat, lowc;
    bit feat_ok, rdy_ok, stable_ok;
    logic [2:0] cls0;
    ep = exp_packed();
    ecls = nib_sum(ep) % NC;
    lat = 0; lowc = 0; feat_ok = 1; rdy_ok = 1; stable_ok = 1;
    chk("feat_packed", 64'(features), 64'(ep));
    out_ready = rdy_hi;
    while (!out_valid && lat < 200) begin
      if (!clf_rst) lowc++;
      if (features !== ep) feat_ok = 0;
      if (in_ready !== 1'b0) rdy_ok = 0;
      if (hold_vld) begin
        in_valid = 1'b1;
        in_data  = FB'($urandom);
      end
      step();
      lat++;
    end
    in_valid = 1'b0;
    chk("latency", 64'(lat), 64'(1 + RUN));
    chk("clf_rst_low", 64'(lowc), 64'(RUN));
    chk("feat_stable", 64'(feat_ok), 64'd1);
    chk("in_rdy_busy", 64'(rdy_ok), 64'd1);
    chk("out_class", 64'(out_class), 64'(ecls));
    if (rdy_hi) begin
      step();
      chk("pulse_1cyc", 64'(out_valid), 64'd0);
    end else begin
      cls0 = out_class;
      for (int i = 0; i < hold; i++) begin
        if (out_valid !== 1'b1 || out_class !== cls0 || features !== ep) stable_ok = 0;
        step();
      end
      chk("done_stable", 64'(stable_ok), 64'd1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("done_consumed", 64'(out_valid), 64'd0);
    end
    chk("back_to_load", 64'(in_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int spurious;
    // Reset state
    #2 rst = 1'b1;
    #1;
    chk("rst_features", 64'(features), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_clf_rst", 64'(clf_rst), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_class", 64'(out_class), 64'd0);
    step(); step();
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 64'(in_ready), 64'd1);

    // Words 0x1..0xB back to back, result held for 10 cycles
    for (int i = 0; i < FC; i++) cur[i] = FB'(i + 1);
    load_sample(0, 0);
    chk("feat_0x123456789AB", 64'(features), 64'h123456789AB);
    finish_sample(0, 10, 0);

    // Same data with in_valid toggling, in_valid held high while running
    load_sample(1, 1);
    finish_sample(1, 0, 0);

    // Reset after five features discards the partial sample
    rand_cur();
    for (int i = 0; i < 5; i++) send_word(cur[i]);
    #2 rst = 1'b1;
    #1;
    chk("midload_features", 64'(features), 64'd0);
    chk("midload_in_ready", 64'(in_ready), 64'd0);
    chk("midload_clf_rst", 64'(clf_rst), 64'd1);
    step(); step();
    rst = 1'b0;
    rand_cur();
    load_sample(0, 1);
    finish_sample(0, 2, 0);

    // Reset at RUN cycle 20 drops the result
    rand_cur();
    load_sample(0, 0);
    repeat (21) step();
    chk("run_clf_rst_low", 64'(clf_rst), 64'd0);
    #2 rst = 1'b1;
    #1;
    chk("midrun_clf_rst", 64'(clf_rst), 64'd1);
    chk("midrun_out_valid", 64'(out_valid), 64'd0);
    chk("midrun_in_ready", 64'(in_ready), 64'd0);
    step(); step();
    rst = 1'b0;
    #1;
    chk("midrun_load", 64'(in_ready), 64'd1);
    spurious = 0;
    for (int i = 0; i < 60; i++) begin
      if (out_valid) spurious++;
      step();
    end
    chk("midrun_no_result", 64'(spurious), 64'd0);

    // Back-to-back samples with out_ready tied high
    out_ready = 1'b1;
    for (int s = 0; s < 2; s++) begin
      rand_cur();
      cur[0] = FB'(s * 3 + 1);
      load_sample(0, 0);
      finish_sample(0, 0, 1);
    end
    out_ready = 1'b0;

    // Randomized samples
    for (int s = 0; s < 6; s++) begin
      rand_cur();
      load_sample(0, int'($urandom_range(3, 0)));
      finish_sample(1'($urandom), int'($urandom_range(4, 0)), 1'($urandom));
      out_ready = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
